// File: rtl/dds_bus_pkg.sv
// Shared constants for the DDS register-write sequencer: register map, CTRL bits, sequencer states.
// No logic; no latency or backpressure of its own.
package dds_bus_pkg;

  localparam int unsigned ADDR_FREQ_LO  = 0;
  localparam int unsigned ADDR_FREQ_HI  = 1;
  localparam int unsigned ADDR_PHASE    = 2;
  localparam int unsigned ADDR_WAVE_SEL = 3;
  localparam int unsigned ADDR_RAM_PTR  = 4;
  localparam int unsigned ADDR_RAM_DATA = 5;
  localparam int unsigned ADDR_CTRL     = 6;

  localparam int unsigned CTRL_RUN    = 0;
  localparam int unsigned CTRL_SCLR   = 1;
  localparam int unsigned CTRL_ERRCLR = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    LO_HELD = 1'b1
  } seq_state_t;

endpackage

// File: rtl/bus_strobe_sync.sv
// Synchronises the async MCU write strobe and captures addr/data while the strobe is low.
// Latency: wr_evt is high for one cycle, 2 clk edges after the first edge that samples bus_wr_n high.
// Backpressure: none; a strobe shorter than 2 clk may be missed.
module bus_strobe_sync #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bus_wr_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [15:0]       bus_data,
  output logic              wr_evt,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [15:0]       cap_data
);

  logic s1, s2, s3;

  // Idle level is high so a strobe still low at reset release yields exactly one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      s1 <= bus_wr_n;
      s2 <= s1;
      s3 <= s2;
      if (!s1) begin
        cap_addr <= bus_addr;
        cap_data <= bus_data;
      end
    end
  end

  assign wr_evt = s2 & ~s3;

endmodule

// File: rtl/dds_bus_ctrl.sv
// Register-write sequencer from the MCU bus to the DDS datapath (freq/phase/wave latch/wave-RAM loader).
// Latency: registers and 1-cycle pulses update 3 clk edges after the bus_wr_n rise; DDS_READBACK_EN adds a registered read port.
// Backpressure: none; the MCU is trusted to space its writes.
module dds_bus_ctrl
  import dds_bus_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [15:0]       bus_data,
  input  logic              bus_wr_n,
`ifdef DDS_READBACK_EN
  input  logic              bus_rd_n,
  output logic [15:0]       rd_data,
`endif
  output logic [15:0]       otdata,
  output logic              cs,
  output logic [31:0]       freq_word,
  output logic              freq_upd,
  output logic [15:0]       phase_word,
  output logic              phase_upd,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              run_en,
  output logic              seq_err
);

  localparam logic [ADDR_W-1:0] A_FREQ_LO  = ADDR_W'(ADDR_FREQ_LO);
  localparam logic [ADDR_W-1:0] A_FREQ_HI  = ADDR_W'(ADDR_FREQ_HI);
  localparam logic [ADDR_W-1:0] A_PHASE    = ADDR_W'(ADDR_PHASE);
  localparam logic [ADDR_W-1:0] A_WAVE_SEL = ADDR_W'(ADDR_WAVE_SEL);
  localparam logic [ADDR_W-1:0] A_RAM_PTR  = ADDR_W'(ADDR_RAM_PTR);
  localparam logic [ADDR_W-1:0] A_RAM_DATA = ADDR_W'(ADDR_RAM_DATA);
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(ADDR_CTRL);

  logic              wr_evt;
  logic [ADDR_W-1:0] cap_addr;
  logic [15:0]       cap_data;
  logic [15:0]       freq_lo;
  logic [RAM_AW-1:0] ptr;
  seq_state_t        state, state_nxt;

  bus_strobe_sync #(.ADDR_W(ADDR_W)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus_wr_n (bus_wr_n),
    .bus_addr (bus_addr),
    .bus_data (bus_data),
    .wr_evt   (wr_evt),
    .cap_addr (cap_addr),
    .cap_data (cap_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_evt) begin
      case (cap_addr)
        A_FREQ_LO: state_nxt = LO_HELD;
        A_FREQ_HI: state_nxt = IDLE;
        A_CTRL:    if (cap_data[CTRL_SCLR]) state_nxt = IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      otdata     <= '0;
      cs         <= 1'b0;
      freq_word  <= '0;
      freq_upd   <= 1'b0;
      phase_word <= '0;
      phase_upd  <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_data   <= '0;
      run_en     <= 1'b0;
      seq_err    <= 1'b0;
      freq_lo    <= '0;
      ptr        <= '0;
    end else begin
      cs        <= 1'b0;
      freq_upd  <= 1'b0;
      phase_upd <= 1'b0;
      ram_we    <= 1'b0;
      if (wr_evt) begin
        case (cap_addr)
          A_FREQ_LO: freq_lo <= cap_data;
          A_FREQ_HI: begin
            // An orphan high half still commits, but flags the missing low half.
            freq_word <= {cap_data, freq_lo};
            freq_upd  <= 1'b1;
            if (state == IDLE) seq_err <= 1'b1;
          end
          A_PHASE: begin
            phase_word <= cap_data;
            phase_upd  <= 1'b1;
          end
          A_WAVE_SEL: begin
            otdata <= cap_data;
            cs     <= 1'b1;
          end
          A_RAM_PTR: ptr <= cap_data[RAM_AW-1:0];
          A_RAM_DATA: begin
            ram_addr <= ptr;
            ram_data <= cap_data;
            ram_we   <= 1'b1;
            ptr      <= ptr + RAM_AW'(1);
          end
          A_CTRL: begin
            run_en <= cap_data[CTRL_RUN];
            // Soft clear wins over the error clear; the run bit always applies.
            if (cap_data[CTRL_SCLR]) begin
              freq_word  <= '0;
              phase_word <= '0;
              freq_lo    <= '0;
              ptr        <= '0;
            end else if (cap_data[CTRL_ERRCLR]) begin
              seq_err <= 1'b0;
            end
          end
          default: seq_err <= 1'b1;
        endcase
      end
    end
  end

`ifdef DDS_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (bus_rd_n) begin
      rd_data <= '0;
    end else begin
      case (bus_addr)
        A_FREQ_LO: rd_data <= freq_word[15:0];
        A_FREQ_HI: rd_data <= freq_word[31:16];
        A_PHASE:   rd_data <= phase_word;
        A_WAVE_SEL: rd_data <= otdata;
        A_RAM_PTR: rd_data <= 16'(ptr);
        A_CTRL:    rd_data <= {13'b0, seq_err, 1'b0, run_en};
        default:   rd_data <= '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dds_bus_ctrl.sv
// Directed bench for dds_bus_ctrl: each write is followed by a 6-cycle window that counts pulses.
module tb_dds_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  bus_addr = '0;
  logic [15:0] bus_data = '0;
  logic        bus_wr_n = 1'b1;
  logic [15:0] otdata;
  logic        cs;
  logic [31:0] freq_word;
  logic        freq_upd;
  logic [15:0] phase_word;
  logic        phase_upd;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic        run_en;
  logic        seq_err;
`ifdef DDS_READBACK_EN
  logic        bus_rd_n = 1'b1;
  logic [15:0] rd_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_cs, n_fu, n_pu, n_we, cs_cyc;
  logic [9:0]  we_addr;
  logic [15:0] we_data;

  always #5 clk = ~clk;

  dds_bus_ctrl #(.ADDR_W(4), .RAM_AW(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_wr_n   (bus_wr_n),
`ifdef DDS_READBACK_EN
    .bus_rd_n   (bus_rd_n),
    .rd_data    (rd_data),
`endif
    .otdata     (otdata),
    .cs         (cs),
    .freq_word  (freq_word),
    .freq_upd   (freq_upd),
    .phase_word (phase_word),
    .phase_upd  (phase_upd),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .run_en     (run_en),
    .seq_err    (seq_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Release the strobe at a negedge, then sample 6 cycles at posedge+1.
  task automatic rise_and_watch();
    bus_wr_n = 1'b1;
    n_cs = 0; n_fu = 0; n_pu = 0; n_we = 0; cs_cyc = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (cs) begin n_cs++; cs_cyc = k; end
      if (freq_upd) n_fu++;
      if (phase_upd) n_pu++;
      if (ram_we) begin n_we++; we_addr = ram_addr; we_data = ram_data; end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus_addr = a; bus_data = d; bus_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    rise_and_watch();
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_freq", freq_word, 32'h0);
    chk("rst_misc", {otdata, phase_word, ram_data, 6'b0, ram_addr}, 64'h0);
    chk("rst_bits", {cs, freq_upd, phase_upd, ram_we, run_en, seq_err}, 6'b0);
    do_reset();

    wr(4'h3, 16'h00A5);
    chk("ws_otdata", otdata, 32'h00A5);
    chk("ws_cs_cnt", n_cs, 1);
    chk("ws_cs_cyc", cs_cyc, 3);
    chk("ws_other", n_fu + n_pu + n_we, 0);

    wr(4'h0, 16'h5678);
    chk("flo_no_upd", n_fu, 0);
    wr(4'h1, 16'h1234);
    chk("freq_word", freq_word, 32'h12345678);
    chk("freq_upd_cnt", n_fu, 1);
    chk("freq_err", seq_err, 0);

    do_reset();
    wr(4'h1, 16'hBEEF);
    chk("orphan_word", freq_word, 32'hBEEF0000);
    chk("orphan_upd", n_fu, 1);
    chk("orphan_err", seq_err, 1);
    wr(4'h6, 16'h0004);
    chk("errclr", seq_err, 0);

    wr(4'h4, 16'h03FE);
    chk("ptr_no_we", n_we, 0);
    wr(4'h5, 16'h0011);
    chk("ram0_cnt", n_we, 1);
    chk("ram0_addr", we_addr, 32'h3FE);
    chk("ram0_data", we_data, 32'h11);
    wr(4'h5, 16'h0022);
    chk("ram1_addr", we_addr, 32'h3FF);
    chk("ram1_data", we_data, 32'h22);
    wr(4'h5, 16'h0033);
    chk("ram2_wrap", we_addr, 32'h000);
    chk("ram2_data", we_data, 32'h33);

    wr(4'h2, 16'hABCD);
    chk("phase_word", phase_word, 32'hABCD);
    chk("phase_upd", n_pu, 1);
    wr(4'h4, 16'h0123);
    wr(4'h0, 16'h1111);
    wr(4'h1, 16'h2222);
    chk("freq2", freq_word, 32'h22221111);
    wr(4'h6, 16'h0003);
    chk("sclr_freq", freq_word, 32'h0);
    chk("sclr_phase", phase_word, 32'h0);
    chk("sclr_run", run_en, 1);
    chk("sclr_noupd", n_fu + n_pu, 0);
    wr(4'h5, 16'h0044);
    chk("sclr_ptr", we_addr, 32'h000);

    wr(4'h9, 16'h0000);
    chk("unmapped_err", seq_err, 1);
    chk("unmapped_nop", n_cs + n_fu + n_pu + n_we, 0);
    wr(4'h6, 16'h0006);
    chk("sclr_beats_errclr", seq_err, 1);
    wr(4'h6, 16'h0004);
    chk("errclr2", seq_err, 0);
    chk("run_off", run_en, 0);
    wr(4'h0, 16'hAAAA);
    wr(4'h0, 16'hBBBB);
    wr(4'h1, 16'hCCCC);
    chk("lo_overwrite", freq_word, 32'hCCCCBBBB);
    chk("lo_overwrite_err", seq_err, 0);

    // Reset while the strobe is held low; data is changed during reset.
    @(negedge clk);
    bus_addr = 4'h3; bus_data = 16'h0055; bus_wr_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_freq", freq_word, 32'h0);
    chk("midrst_otdata", otdata, 32'h0);
    bus_data = 16'h0077;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rise_and_watch();
    chk("midrst_cs_cnt", n_cs, 1);
    chk("midrst_otdata2", otdata, 32'h0077);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_quiet", cs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dds_bus_ctrl.md
Name: dds_bus_ctrl

Overview:
- Register-write sequencer between the MCU parallel bus and the DDS datapath.
- Synchronises the asynchronous MCU write strobe and decodes the register address.
- Assembles 32-bit words from 16-bit halves and commits them atomically.
- Drives the waveform-select latch (otdata/cs), the phase/frequency registers and the wave-RAM loader with an auto-incrementing pointer.

Parameters:
- ADDR_W, 4, bus address width.
- RAM_AW, 10, wave-RAM address width; pointer wraps at 2^RAM_AW.

Ports:
- clk  in  1  system clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- bus_addr  in  ADDR_W  MCU address; stable ≥2 clk before the bus_wr_n rise.
- bus_data  in  16  MCU write data; same stability rule as bus_addr.
- bus_wr_n  in  1  MCU write strobe, async, active-low; the write completes on its rising edge.
- otdata  out  16  waveform-select word to the wave latch.
- cs  out  1  1-cycle load pulse to the wave latch.
- freq_word  out  32  committed frequency tuning word.
- freq_upd  out  1  1-cycle pulse on freq_word commit.
- phase_word  out  16  phase offset.
- phase_upd  out  1  1-cycle pulse on phase_word write.
- ram_we  out  1  1-cycle wave-RAM write enable.
- ram_addr  out  RAM_AW  wave-RAM write address.
- ram_data  out  16  wave-RAM write data.
- run_en  out  1  DDS accumulator enable.
- seq_err  out  1  sticky error flag.

Behaviour:
- Reset: every output 0; FSM in IDLE; freq_lo staging register 0; pointer 0.
- Synchroniser: bus_wr_n passes through 2 flops (s1, s2) plus an s3 delay flop.
- Write event: s2 & ~s3.
- Capture: bus_addr/bus_data are registered on every clk while s1 is low; the event uses these captured values.
- Latency: all register outputs and pulses update on the clk edge where the event is high, i.e. 3 clk edges after the first edge that samples bus_wr_n high.
- Strobe length: a strobe low for <2 clk may be missed. This is not an error.
- Decode (captured addr):
  - 0x0 FREQ_LO: freq_lo <= data; FSM -> LO_HELD.
  - 0x1 FREQ_HI: freq_word <= {data, freq_lo}; freq_upd pulse; FSM -> IDLE. If FSM was IDLE, still commit and set seq_err.
  - 0x2 PHASE: phase_word <= data; phase_upd pulse.
  - 0x3 WAVE_SEL: otdata <= data; cs pulse. otdata holds until the next WAVE_SEL.
  - 0x4 RAM_PTR: pointer <= data[RAM_AW-1:0]; no ram_we.
  - 0x5 RAM_DATA: ram_addr <= pointer; ram_data <= data; ram_we pulse; pointer <= pointer+1, wrapping from 2^RAM_AW-1 to 0.
  - 0x6 CTRL:
    - bit0 -> run_en.
    - bit1 = soft clear: freq_word, phase_word, freq_lo and pointer -> 0; FSM -> IDLE. No upd pulses.
    - bit2 = clear seq_err.
    - Soft clear takes priority over the other bits in the same write; bit0 is still applied.
  - Other addresses: ignored; seq_err set.
- FSM states: IDLE and LO_HELD only.
  - FREQ_LO in LO_HELD: overwrites freq_lo, stays in LO_HELD.
  - Other addresses do not change FSM state.
- Pulses (cs, freq_upd, phase_upd, ram_we) are exactly 1 cycle wide and occur at most once per write event.
- Reset mid-strobe: all state clears. A bus_wr_n still low at reset release produces an event on its rise, using data captured after reset.
- Pulse/data alignment: ram_addr and ram_data are valid in the same cycle as ram_we. cs pulses in the same cycle otdata updates.

Optional Feature:
- Macro: DDS_READBACK_EN.
- Defined:
  - Adds ports bus_rd_n (in, 1) and rd_data (out, 16).
  - rd_data is a registered mux of the register at bus_addr: freq halves, phase, otdata, pointer, CTRL = {13'b0, seq_err, 1'b0, run_en}.
  - Updates every clk; 0 for unmapped addresses and while bus_rd_n is high.
  - Reads have no side effects.
- Undefined: no read ports; write path identical.

Decomposition:
- Package dds_bus_pkg: address constants ADDR_FREQ_LO..ADDR_CTRL, CTRL bit indices, FSM state enum {IDLE, LO_HELD}.
- Sub-module bus_strobe_sync: 2-flop sync, s3 delay, edge detect and addr/data capture. Outputs: wr_evt, cap_addr, cap_data.

Test Plan:
- Write 0x3 = 0x00A5 → otdata = 0x00A5, cs high exactly 1 cycle, 3 clk after the strobe rise; no other pulse.
- Write 0x0 = 0x5678 then 0x1 = 0x1234 → freq_word = 0x12345678 with a single freq_upd; seq_err = 0.
- Write 0x1 = 0xBEEF from reset → freq_word = 0xBEEF0000, freq_upd pulses, seq_err = 1; write 0x6 = 0x0004 → seq_err = 0.
- RAM_AW=10: write 0x4 = 0x03FE, then 0x5 three times with 0x11, 0x22, 0x33 → ram_we pulses at ram_addr 0x3FE, 0x3FF, 0x000.
- After freq/phase loads, write 0x6 = 0x0003 → freq_word = 0, phase_word = 0, pointer = 0, run_en = 1, no upd pulses.
- Assert rst_n low during a held-low bus_wr_n → all outputs 0 immediately; after release, the strobe rise produces exactly one event.
